// File: rtl/ram_loader.sv
// Byte-stream RAM loader: assembles high-byte-first 16-bit words into a 2**ADDR_W x 16 RAM
// and holds the CPU off the RAM port while a load is in progress.
module ram_loader #(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Length,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic [15:0]       CpuWriteData,
  input  logic              CpuWE,
  input  logic              CpuRE,
  output logic [15:0]       CpuReadData,
  output logic [ADDR_W-1:0] RamAddress,
  output logic [15:0]       RamWriteData,
  output logic              RamWE,
  output logic              RamRE,
  input  logic [15:0]       RamReadData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   WordCount
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        hi_byte, lo_byte;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   wc_inc;
  logic              cap_start, take_hi, take_lo, do_write;

  // A load can never write more words than the RAM holds.
  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  assign wc_inc = WordCount + (ADDR_W+1)'(1);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ByteReady = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    cap_start = 1'b0;
    take_hi   = 1'b0;
    take_lo   = 1'b0;
    do_write  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        Done = (state == S_DONE);
        if (Start) begin
          cap_start = 1'b1;
          state_nxt = (Length == '0) ? S_DONE : S_HI;
        end
      end
      S_HI: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid) begin
          take_hi   = 1'b1;
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid) begin
          take_lo   = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        Busy      = 1'b1;
        do_write  = 1'b1;
        state_nxt = (wc_inc == len) ? S_DONE : S_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      hi_byte   <= '0;
      lo_byte   <= '0;
      ptr       <= BASE_ADDR;
      len       <= '0;
      WordCount <= '0;
    end else begin
      if (cap_start) begin
        len       <= sat_len(Length);
        ptr       <= BASE_ADDR;
        WordCount <= '0;
      end
      if (take_hi) hi_byte <= ByteIn;
      if (take_lo) lo_byte <= ByteIn;
      // Pointer wraps modulo the RAM depth.
      if (do_write) begin
        ptr       <= ptr + ADDR_W'(1);
        WordCount <= wc_inc;
      end
    end
  end

  // While busy the CPU enables are dropped, not deferred.
  assign RamAddress   = Busy ? ptr : CpuAddress;
  assign RamWriteData = Busy ? {hi_byte, lo_byte} : CpuWriteData;
  assign RamWE        = Busy ? do_write : CpuWE;
  assign RamRE        = Busy ? 1'b0 : CpuRE;
  assign CpuReadData  = Busy ? 16'h0000 : RamReadData;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: passthrough, timed load, stalled load, wrap, corner cases, reset.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  length = '0;
  logic [7:0]  byte_in = '0;
  logic        start0 = 1'b0, start1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0, cpu_re = 1'b0;

  logic        ready0, ram_we0, ram_re0, busy0, done0;
  logic        ready1, ram_we1, ram_re1, busy1, done1;
  logic [15:0] cpu_rdata0, ram_wdata0, ram_rdata0;
  logic [15:0] cpu_rdata1, ram_wdata1, ram_rdata1;
  logic [7:0]  ram_addr0, ram_addr1;
  logic [8:0]  wc0, wc1;

  logic [15:0] mem0 [256] = '{default: 16'h0000};
  logic [15:0] mem1 [256] = '{default: 16'h0000};
  int          we_cnt0 = 0, we_cnt1 = 0;

  int tests = 0, failed = 0, rdy_err = 0, dist_err = 0;
  logic [7:0] stream [8];

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .Clk(clk), .nReset(rst_n), .Start(start0), .Length(length), .ByteIn(byte_in),
    .ByteValid(valid0), .ByteReady(ready0), .CpuAddress(cpu_addr), .CpuWriteData(cpu_wdata),
    .CpuWE(cpu_we), .CpuRE(cpu_re), .CpuReadData(cpu_rdata0), .RamAddress(ram_addr0),
    .RamWriteData(ram_wdata0), .RamWE(ram_we0), .RamRE(ram_re0), .RamReadData(ram_rdata0),
    .Busy(busy0), .Done(done0), .WordCount(wc0));

  ram_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .Clk(clk), .nReset(rst_n), .Start(start1), .Length(length), .ByteIn(byte_in),
    .ByteValid(valid1), .ByteReady(ready1), .CpuAddress(cpu_addr), .CpuWriteData(cpu_wdata),
    .CpuWE(cpu_we), .CpuRE(cpu_re), .CpuReadData(cpu_rdata1), .RamAddress(ram_addr1),
    .RamWriteData(ram_wdata1), .RamWE(ram_we1), .RamRE(ram_re1), .RamReadData(ram_rdata1),
    .Busy(busy1), .Done(done1), .WordCount(wc1));

  assign ram_rdata0 = mem0[ram_addr0];
  assign ram_rdata1 = mem1[ram_addr1];

  always @(posedge clk) begin
    if (ram_we0) begin
      mem0[ram_addr0] <= ram_wdata0;
      we_cnt0 <= we_cnt0 + 1;
    end
    if (ram_we1) begin
      mem1[ram_addr1] <= ram_wdata1;
      we_cnt1 <= we_cnt1 + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    logic        we, re;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    logic        rdy, busy, done, we;
    logic [7:0]  addr;
    logic [15:0] data;
  } cyc_t;

  vec_t pt [5];
  cyc_t t2 [11];

  task automatic do_load(input bit sel, input logic [8:0] len, input int nb, input bit gaps,
                         input bit chk, input bit disturb, input int abort_at, output int cyc);
    int idx;
    bit hs, v, rdy, bsy, dn, we;
    idx = 0;
    cyc = 0;
    length = len;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    while (cyc < 300) begin
      byte_in = (idx < nb) ? stream[idx] : 8'h00;
      v = (idx < nb) && (!gaps || $urandom_range(0, 2) != 0);
      if (sel) valid1 = v; else valid0 = v;
      if (disturb) begin
        if (cyc >= 2 && cyc <= 5) begin
          start0 = 1'b1; length = 9'd5;
          cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 8'd9; cpu_wdata = 16'hFFFF;
        end else begin
          cpu_we = 1'b0; cpu_re = 1'b0;
        end
      end
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_wc", {23'd0, wc0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      rdy = sel ? ready1 : ready0;
      bsy = sel ? busy1 : busy0;
      dn  = sel ? done1 : done0;
      we  = sel ? ram_we1 : ram_we0;
      hs  = v && rdy;
      if (chk && cyc < 11) begin
        check($sformatf("t2_rdy_c%0d", cyc), {31'd0, rdy}, {31'd0, t2[cyc].rdy});
        check($sformatf("t2_busy_c%0d", cyc), {31'd0, bsy}, {31'd0, t2[cyc].busy});
        check($sformatf("t2_done_c%0d", cyc), {31'd0, dn}, {31'd0, t2[cyc].done});
        check($sformatf("t2_we_c%0d", cyc), {31'd0, we}, {31'd0, t2[cyc].we});
        if (t2[cyc].we) begin
          check($sformatf("t2_addr_c%0d", cyc), {24'd0, ram_addr0}, {24'd0, t2[cyc].addr});
          check($sformatf("t2_data_c%0d", cyc), {16'd0, ram_wdata0}, {16'd0, t2[cyc].data});
        end
      end
      if (gaps && bsy && !we && !rdy) rdy_err++;
      if (disturb && busy0 && (cpu_rdata0 !== 16'h0000 || ram_re0 !== 1'b0)) dist_err++;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (dn && cyc > 0) break;
      if (hs) idx++;
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  initial begin
    int cyc, base_cnt;
    pt[0] = '{a: 8'd9,  d: 16'h1234, we: 1'b1, re: 1'b0, rd: 16'h0000};
    pt[1] = '{a: 8'd9,  d: 16'h0000, we: 1'b0, re: 1'b1, rd: 16'h1234};
    pt[2] = '{a: 8'd20, d: 16'hABCD, we: 1'b1, re: 1'b0, rd: 16'h0000};
    pt[3] = '{a: 8'd20, d: 16'h0000, we: 1'b0, re: 1'b1, rd: 16'hABCD};
    pt[4] = '{a: 8'd9,  d: 16'h5555, we: 1'b0, re: 1'b0, rd: 16'h1234};
    for (int i = 0; i < 11; i++) t2[i] = '{rdy: 1'b1, busy: 1'b1, done: 1'b0, we: 1'b0, addr: 8'h00, data: 16'h0000};
    t2[0]  = '{rdy: 1'b0, busy: 1'b0, done: 1'b0, we: 1'b0, addr: 8'h00, data: 16'h0000};
    t2[3]  = '{rdy: 1'b0, busy: 1'b1, done: 1'b0, we: 1'b1, addr: 8'h00, data: 16'h1234};
    t2[6]  = '{rdy: 1'b0, busy: 1'b1, done: 1'b0, we: 1'b1, addr: 8'h01, data: 16'h5678};
    t2[9]  = '{rdy: 1'b0, busy: 1'b1, done: 1'b0, we: 1'b1, addr: 8'h02, data: 16'h9ABC};
    t2[10] = '{rdy: 1'b0, busy: 1'b0, done: 1'b1, we: 1'b0, addr: 8'h00, data: 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_ready", {31'd0, ready0}, 32'd0);
    check("reset_done", {31'd0, done0}, 32'd0);
    check("reset_wc", {23'd0, wc0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 passthrough
    for (int i = 0; i < 5; i++) begin
      cpu_addr = pt[i].a; cpu_wdata = pt[i].d; cpu_we = pt[i].we; cpu_re = pt[i].re;
      @(negedge clk);
      check($sformatf("pt%0d_we", i), {31'd0, ram_we0}, {31'd0, pt[i].we});
      check($sformatf("pt%0d_re", i), {31'd0, ram_re0}, {31'd0, pt[i].re});
      check($sformatf("pt%0d_addr", i), {24'd0, ram_addr0}, {24'd0, pt[i].a});
      check($sformatf("pt%0d_wdata", i), {16'd0, ram_wdata0}, {16'd0, pt[i].d});
      check($sformatf("pt%0d_rdata", i), {16'd0, cpu_rdata0}, {16'd0, pt[i].rd});
      @(posedge clk); #1;
    end
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0;

    // T2 back-to-back load
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00};
    base_cnt = we_cnt0;
    do_load(1'b0, 9'd3, 6, 1'b0, 1'b1, 1'b0, -1, cyc);
    check("t2_cycles", cyc, 32'd10);
    check("t2_wc", {23'd0, wc0}, 32'd3);
    check("t2_we_count", we_cnt0 - base_cnt, 32'd3);
    check("t2_mem1", {16'd0, mem0[1]}, 32'h5678);

    // T3 stalled load
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    base_cnt = we_cnt0;
    do_load(1'b0, 9'd3, 6, 1'b1, 1'b0, 1'b0, -1, cyc);
    check("t3_no_timeout", {31'd0, cyc < 300}, 32'd1);
    check("t3_we_count", we_cnt0 - base_cnt, 32'd3);
    check("t3_mem0", {16'd0, mem0[0]}, 32'h1122);
    check("t3_mem1", {16'd0, mem0[1]}, 32'h3344);
    check("t3_mem2", {16'd0, mem0[2]}, 32'h5566);
    check("t3_wc", {23'd0, wc0}, 32'd3);
    check("t3_ready_held", rdy_err, 32'd0);

    // T5 Start and CPU access while busy
    stream = '{8'hC0, 8'hDE, 8'hF0, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    base_cnt = we_cnt0;
    do_load(1'b0, 9'd2, 4, 1'b0, 1'b0, 1'b1, -1, cyc);
    check("t5_cycles", cyc, 32'd7);
    check("t5_wc", {23'd0, wc0}, 32'd2);
    check("t5_we_count", we_cnt0 - base_cnt, 32'd2);
    check("t5_cpu_blocked", {16'd0, mem0[9]}, 32'h1234);
    check("t5_cpu_hold", dist_err, 32'd0);
    check("t5_mem0", {16'd0, mem0[0]}, 32'hC0DE);

    // T6 reset in LO after one word
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
    base_cnt = we_cnt0;
    do_load(1'b0, 9'd3, 6, 1'b0, 1'b0, 1'b0, 5, cyc);
    repeat (4) @(posedge clk);
    #1;
    check("t6_we_count", we_cnt0 - base_cnt, 32'd1);
    check("t6_mem0", {16'd0, mem0[0]}, 32'hAABB);
    check("t6_mem1", {16'd0, mem0[1]}, 32'hF00D);
    check("t6_idle_busy", {31'd0, busy0}, 32'd0);
    check("t6_idle_done", {31'd0, done0}, 32'd0);

    // T5 Length=0 from IDLE
    base_cnt = we_cnt0;
    length = 9'd0; start0 = 1'b1;
    @(negedge clk);
    check("len0_done_pre", {31'd0, done0}, 32'd0);
    @(posedge clk); #1;
    start0 = 1'b0;
    @(negedge clk);
    check("len0_done", {31'd0, done0}, 32'd1);
    check("len0_busy", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    check("len0_no_we", we_cnt0 - base_cnt, 32'd0);

    // T4 wrap on the FE-based instance
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    base_cnt = we_cnt1;
    do_load(1'b1, 9'd3, 6, 1'b0, 1'b0, 1'b0, -1, cyc);
    check("t4_cycles", cyc, 32'd10);
    check("t4_we_count", we_cnt1 - base_cnt, 32'd3);
    check("t4_memFE", {16'd0, mem1[8'hFE]}, 32'h0102);
    check("t4_memFF", {16'd0, mem1[8'hFF]}, 32'h0304);
    check("t4_mem00", {16'd0, mem1[8'h00]}, 32'h0506);
    check("t4_wc", {23'd0, wc1}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
